// File: rtl/fetch_pkg.sv
// Shared widths, queue entry type and PC increment for the instruction fetch front end.
package fetch_pkg;
    localparam int ADDR_W  = 64;
    localparam int INST_W  = 32;
    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/inst_fifo.sv
// Circular buffer of fetched instructions; head is read combinationally, flush empties it in one cycle.
module inst_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  fetch_entry_t             push_entry_i,
    input  logic                     pop_i,
    output fetch_entry_t             head_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W:0] FULL = CNT_W'(DEPTH);

    fetch_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               do_pop;

    assign do_pop  = pop_i & (count_q != '0);
    assign head_o  = mem_q[head_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) tail_d = tail_q + PTR_W'(1);
            if (do_pop) head_d = head_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_i) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[tail_q] <= push_entry_i;
    end

    // The issue rule upstream reserves a slot for every request, so a full-queue push is a design bug.
    always @(posedge clk) begin
        if (rst && push_i && !flush_i) begin
            assert (count_q != FULL);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues sequential reads to a
// one-cycle synchronous instruction memory and queues the returned words for decode.
module fetch_unit #(
    parameter int                ADDR_W   = fetch_pkg::ADDR_W,
    parameter int                INST_W   = fetch_pkg::INST_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [INST_W-1:0]        imem_data,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [INST_W-1:0]        inst,
    output logic [ADDR_W-1:0]        inst_pc,
    output logic [ADDR_W-1:0]        inst_pc_plus4,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic [$clog2(DEPTH):0]   occupancy
);
    import fetch_pkg::*;

    localparam int              CNT_W   = $clog2(DEPTH) + 1;
    localparam int              DEM_W   = CNT_W + 1;
    localparam int              E_ADDR  = $bits(fetch_entry_t) - fetch_pkg::INST_W;
    localparam int              E_INST  = fetch_pkg::INST_W;
    localparam logic [DEM_W-1:0] DEPTH_C = DEM_W'(DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic              pop, push, flush;
    logic [DEM_W-1:0]  demand;
    fetch_entry_t      push_entry, head_entry;

    assign pop   = inst_valid & inst_ready;
    assign flush = ~rst | redirect_valid;
    assign push  = inflight_q & ~flush;

    // Slots already promised: queued entries plus the response still on its way, minus what leaves now.
    assign demand   = DEM_W'(occupancy) + DEM_W'(inflight_q) - DEM_W'(pop);
    assign imem_req = rst & ~redirect_valid & (demand < DEPTH_C);
    assign imem_addr = pc_q;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = imem_req;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & ~ADDR_W'(3);
        end else if (imem_req) begin
            pc_d          = pc_q + ADDR_W'(PC_STEP);
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign push_entry.inst = E_INST'(imem_data);
    assign push_entry.pc   = E_ADDR'(inflight_pc_q);

    inst_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head_entry),
        .valid_o      (inst_valid),
        .count_o      (occupancy)
    );

    assign inst          = INST_W'(head_entry.inst);
    assign inst_pc       = ADDR_W'(head_entry.pc);
    assign inst_pc_plus4 = inst_pc + ADDR_W'(PC_STEP);
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed phases plus randomized ready/redirect/reset traffic.
module tb_fetch_unit;
    localparam logic [63:0] RST_PC   = 64'h0;
    localparam logic [63:0] WRAP_PC  = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam int          SEG      = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mem_f(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_0000;
    endfunction

    // main instance: DEPTH 4, RESET_PC 0
    logic        rst, imem_req, inst_valid, inst_ready, redirect_valid;
    logic [63:0] imem_addr, inst_pc, inst_pc_plus4, redirect_pc;
    logic [31:0] imem_data, inst;
    logic [2:0]  occupancy;

    fetch_unit #(.ADDR_W(64), .INST_W(32), .DEPTH(4), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .inst_pc_plus4(inst_pc_plus4), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .occupancy(occupancy)
    );
    always @(posedge clk) imem_data <= mem_f(imem_addr);

    // DEPTH 2 instance and wrap-around instance, both free-running with ready held high
    logic        rst2;
    logic        imem_req_b, inst_valid_b, imem_req_w, inst_valid_w;
    logic [63:0] imem_addr_b, inst_pc_b, inst_pc_plus4_b, imem_addr_w, inst_pc_w, inst_pc_plus4_w;
    logic [31:0] imem_data_b, inst_b, imem_data_w, inst_w;
    logic [1:0]  occupancy_b;
    logic [2:0]  occupancy_w;
    logic        one = 1'b1;
    logic        zero = 1'b0;
    logic [63:0] zero64 = 64'h0;

    fetch_unit #(.ADDR_W(64), .INST_W(32), .DEPTH(2), .RESET_PC(RST_PC)) dut_b (
        .clk(clk), .rst(rst2), .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_data(imem_data_b),
        .inst_valid(inst_valid_b), .inst_ready(one), .inst(inst_b), .inst_pc(inst_pc_b),
        .inst_pc_plus4(inst_pc_plus4_b), .redirect_valid(zero), .redirect_pc(zero64),
        .occupancy(occupancy_b)
    );
    always @(posedge clk) imem_data_b <= mem_f(imem_addr_b);

    fetch_unit #(.ADDR_W(64), .INST_W(32), .DEPTH(4), .RESET_PC(WRAP_PC)) dut_w (
        .clk(clk), .rst(rst2), .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_data(imem_data_w),
        .inst_valid(inst_valid_w), .inst_ready(one), .inst(inst_w), .inst_pc(inst_pc_w),
        .inst_pc_plus4(inst_pc_plus4_w), .redirect_valid(zero), .redirect_pc(zero64),
        .occupancy(occupancy_w)
    );
    always @(posedge clk) imem_data_w <= mem_f(imem_addr_w);

    // Reference model: after a reset or redirect to T, decode must accept T, T+4, T+8, ... in order.
    logic [63:0] exp_q [$];
    logic [63:0] exp_b [$];
    logic [63:0] exp_w [$];

    task automatic start_segment(input logic [63:0] tgt);
        exp_q.delete();
        for (int i = 0; i < SEG; i++) exp_q.push_back(tgt + 64'(4 * i));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // main monitor
    int          since = 1000;
    logic [63:0] tgt_m = 64'h0;
    logic        steady = 1'b0;

    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst || redirect_valid) begin
            check("req_low_in_flush", imem_req, 0);
            since = 0;
            tgt_m = !rst ? RST_PC : (redirect_pc & ~64'h3);
        end else begin
            if (since < 1000) since++;
            if (since == 1) begin
                check("post_flush_occ", occupancy, 0);
                check("post_flush_valid", inst_valid, 0);
                check("first_req", imem_req, 1);
                check("first_addr", imem_addr, tgt_m);
            end
            if (since == 3) begin
                check("first_valid", inst_valid, 1);
                check("first_pc", inst_pc, tgt_m);
            end
            if (steady && since >= 3) check("throughput", inst_valid, 1);
            check("valid_vs_occ", inst_valid, occupancy != 0);
            check("occ_le_depth", occupancy <= 3'd4, 1);
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("inst_pc", inst_pc, e);
                    check("inst_pc_plus4", inst_pc_plus4, e + 64'd4);
                    check("inst_data", inst, mem_f(e));
                end
            end
        end
    end

    // auxiliary monitor for DEPTH=2 and wrap-around instances
    int since2 = 1000;
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst2) since2 = 0;
        else if (since2 < 1000) since2++;
        if (since2 == 1) begin
            check("d2_first_req", imem_req_b, 1);
            check("d2_first_addr", imem_addr_b, RST_PC);
            check("wrap_first_addr", imem_addr_w, WRAP_PC);
        end
        if (since2 >= 3 && since2 <= 40) begin
            check("d2_throughput", inst_valid_b, 1);
            check("wrap_throughput", inst_valid_w, 1);
        end
        if (rst2 && since2 <= 40) begin
            if (inst_valid_b) begin
                if (exp_b.size() == 0) check("d2_underflow", 1, 0);
                else begin
                    e = exp_b.pop_front();
                    check("d2_pc", inst_pc_b, e);
                    check("d2_data", inst_b, mem_f(e));
                end
            end
            if (inst_valid_w) begin
                if (exp_w.size() == 0) check("wrap_underflow", 1, 0);
                else begin
                    e = exp_w.pop_front();
                    check("wrap_pc", inst_pc_w, e);
                    check("wrap_pc_plus4", inst_pc_plus4_w, e + 64'd4);
                    check("wrap_data", inst_w, mem_f(e));
                end
            end
        end
    end

    initial begin
        rst2 = 1'b0;
        for (int i = 0; i < 64; i++) begin
            exp_b.push_back(RST_PC + 64'(4 * i));
            exp_w.push_back(WRAP_PC + 64'(4 * i));
        end
        step();
        step();
        rst2 = 1'b1;
    end

    initial begin
        int quiet;
        rst = 1'b0;
        inst_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 64'h0;
        start_segment(RST_PC);
        step();
        step();
        rst = 1'b1;
        steady = 1'b1;
        repeat (30) step();

        // backpressure
        steady = 1'b0;
        inst_ready = 1'b0;
        repeat (10) step();
        check("bp_occ_full", occupancy, 4);
        check("bp_req_low", imem_req, 0);
        inst_ready = 1'b1;
        repeat (10) step();

        // redirect mid-stream with a partly filled queue
        inst_ready = 1'b0;
        repeat (2) step();
        redirect_valid = 1'b1;
        redirect_pc = 64'h400;
        start_segment(64'h400);
        step();
        redirect_valid = 1'b0;
        inst_ready = 1'b1;
        repeat (10) step();

        // unaligned redirect together with a pop
        redirect_valid = 1'b1;
        redirect_pc = 64'h403;
        start_segment(64'h400);
        step();
        redirect_valid = 1'b0;
        repeat (8) step();

        // reset with a full queue
        inst_ready = 1'b0;
        repeat (8) step();
        check("pre_rst_full", occupancy, 4);
        rst = 1'b0;
        start_segment(RST_PC);
        step();
        check("rst_mid_valid", inst_valid, 0);
        rst = 1'b1;
        inst_ready = 1'b1;
        repeat (10) step();

        // randomized traffic
        quiet = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = 1'b1;
            redirect_valid = 1'b0;
            inst_ready = ($urandom_range(0, 99) < 70);
            if (quiet > 150 || $urandom_range(0, 24) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = {$urandom(), $urandom()};
                start_segment(redirect_pc & ~64'h3);
                quiet = 0;
            end else if ($urandom_range(0, 299) == 0) begin
                rst = 1'b0;
                start_segment(RST_PC);
                quiet = 0;
            end else begin
                quiet++;
            end
            step();
        end
        rst = 1'b1;
        redirect_valid = 1'b0;
        repeat (5) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the pipelined CPU, replacing the single-cycle arrangement in which the PC register fed the instruction memory directly. It owns the fetch PC, issues sequential requests to a synchronous-read instruction memory and buffers returned instructions in a small queue. It hands instructions to decode through a valid/ready handshake. A redirect from execute flushes the queue and any in-flight response.

## Interface
- `ADDR_W`, 64, PC and memory address width
- `INST_W`, 32, instruction width
- `DEPTH`, 4, queue entries; power of two, ≥ 2
- `RESET_PC`, 0, first fetch address after reset
- `clk`  in  1  clock; all state updates on its rising edge
- `rst`  in  1  reset; synchronous, active-low
- `imem_req`  out  1  read request this cycle
- `imem_addr`  out  ADDR_W  request address; equals the internal fetch PC
- `imem_data`  in  INST_W  read data; valid exactly one cycle after the request
- `inst_valid`  out  1  queue head is valid
- `inst_ready`  in  1  decode accepts the head this cycle
- `inst`  out  INST_W  head instruction
- `inst_pc`  out  ADDR_W  address of the head instruction
- `inst_pc_plus4`  out  ADDR_W  `inst_pc + 4`, used for branch-link writeback
- `redirect_valid`  in  1  execute resolved a taken branch
- `redirect_pc`  in  ADDR_W  branch target; low two bits ignored and treated as 0
- `occupancy`  out  $clog2(DEPTH)+1  current queue entry count

## Operation
- **Reset** (`rst`=0 at an edge):
  - fetch PC is set to `RESET_PC`.
  - Queue is cleared: `occupancy` = 0, `inst_valid` = 0.
  - In-flight flag is cleared.
  - `imem_req` is 0 for every cycle in which `rst` is 0.
- **Issue rule:** `imem_req` = `rst` & !`redirect_valid` & (occupancy + inflight − pop < DEPTH).
  - pop = `inst_valid` & `inst_ready`.
  - inflight = 1 if a request was issued last cycle and was not cancelled.
- **On issue:** fetch PC ← fetch PC + 4, with modulo 2^ADDR_W wrap. The in-flight flag is set along with the request's PC.
- **Response:** when the in-flight flag is set and not cancelled, `imem_data` and its PC are pushed into the queue at the end of that cycle.
- **Overflow:** by construction of the issue rule the queue never overflows. A push into a full queue is an assertion failure.
- **Pop:** when pop is true, the head advances. Push and pop in the same cycle leave `occupancy` unchanged.
- **Redirect** (`redirect_valid`=1 in cycle n):
  - Queue is cleared at the end of n.
  - A response arriving in n is discarded.
  - `imem_req` = 0 in n.
  - fetch PC ← `redirect_pc` & ~3.
  - `inst_valid` must be ignored by decode in n. A pop in n is harmless.
- **Redirect precedence:** redirect wins over a simultaneous push or pop. Redirect with `rst`=0 behaves as reset.
- **Output source:** `inst`, `inst_pc` and `inst_pc_plus4` come straight from the head entry. They are don't-care when `inst_valid` = 0.

## Timing
- **Request to availability:** request in cycle n → data in n+1 → `inst_valid` in n+2.
- **Reset release:** `rst` goes high before the edge ending cycle r. Then `imem_req`=1 with `imem_addr`=`RESET_PC` in r+1, and the first `inst_valid` is in r+3.
- **Redirect:** in cycle n, first new request in n+1 at the target, first target instruction valid in n+3 (2-cycle bubble).
- **Throughput:** with `inst_ready` held at 1, one instruction per cycle is sustained for every DEPTH ≥ 2.
- **Backpressure:** with `inst_ready`=0, requests stop once occupancy + inflight = DEPTH. Nothing is lost or duplicated.

## Structure
- Package `fetch_pkg` holds:
  - default widths: `ADDR_W`, `INST_W`.
  - a `fetch_entry_t` struct with `inst` and `pc` fields.
  - the constant `PC_STEP` = 4.
- Sub-module `inst_fifo`: parametrised circular buffer of `fetch_entry_t`.
  - Head/tail pointers of $clog2(DEPTH) bits wrap naturally.
  - Count is one bit wider.
  - Synchronous flush input.
- `fetch_unit` contains the PC register, in-flight tracking, issue logic and the `inst_fifo` instance.

## Test plan
- **Reset then free-run:** `rst` low 2 cycles, then high, `inst_ready`=1, memory returns word = address. Addresses 0,4,8,… appear on `inst_pc` on consecutive cycles starting 3 cycles after release. `inst_pc_plus4` = `inst_pc` + 4.
- **Backpressure:** `inst_ready`=0 for 10 cycles with DEPTH=4. `occupancy` saturates at 4 and `imem_req` stays low. Releasing gives 0,4,8,12,16 in order with no gaps or duplicates.
- **Redirect mid-stream:** redirect to 0x400 while 0x10 is in flight and the queue is holding 0x8/0xC.
  - 0x10 is never presented.
  - `imem_req`=0 in the redirect cycle.
  - `inst_pc`=0x400 valid 3 cycles later.
- **Redirect with simultaneous pop, and unaligned target:** `redirect_pc`=0x403 with `inst_ready`=1. Queue empties and the next fetch address is 0x400.
- **Wrap-around:** `RESET_PC`=2^64−8. PCs FFFF…F8, FFFF…FC, 0, 4 appear in sequence.
- **Reset mid-operation and DEPTH=2:** drop `rst` with a full queue. `inst_valid` is 0 the next cycle and fetch restarts at `RESET_PC`. Repeat the free-run test at DEPTH=2 and confirm 1 instruction/cycle.
